// File: rtl/fetch_stage_pkg.sv
// ----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared CPU constants for the fetch stage: default trap vectors, the NOP
// encoding used for IF/ID bubbles, the fetch FSM state type and a PC
// word-alignment helper.
// ----------------------------------------------------------------------------
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
    localparam logic [31:0] IRQ_VECTOR_DEF = 32'h8000_0004;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h8000_0008;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;

    // RUN: normal fetch. PEND: a redirect arrived under stall and is parked.
    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } fstate_e;

    // Instructions are word aligned; the two low PC bits are always zero.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// ----------------------------------------------------------------------------
// fetch_stage_if
// Bundles the fetch stage control inputs, the instruction ROM port and the
// IF/ID outputs.
//   slave  : the fetch stage side (consumes controls/ROM data, drives PC/IF-ID)
//   master : the surrounding pipeline / memory side
// ----------------------------------------------------------------------------
interface fetch_stage_if;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        irq;
    logic        exc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] epc;

    modport slave (
        input  stall, flush, redirect_valid, redirect_pc, irq, exc, imem_rdata,
        output imem_addr, if_pc, id_valid, id_instr, id_pc, id_pc_plus4, epc
    );

    modport master (
        output stall, flush, redirect_valid, redirect_pc, irq, exc, imem_rdata,
        input  imem_addr, if_pc, id_valid, id_instr, id_pc, id_pc_plus4, epc
    );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// ----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register.
//   clk, reset  : clock, async active-low reset
//   load_i      : capture instr/pc/pc+4 and mark valid
//   bubble_i    : insert a NOP bubble (valid=0, instr=NOP); wins over load_i
//   neither     : hold
//   instr_i, pc_i, pc_plus4_i : fetched instruction and its PCs
//   valid_o, instr_o, pc_o, pc_plus4_o : registered IF/ID contents
// ----------------------------------------------------------------------------
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic        bubble_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] pc_plus4_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o
);
    logic        valid_q;
    logic [31:0] instr_q, pc_q, pc_plus4_q;

    // A bubble only kills valid/instr; the PC fields keep their last value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
            pc_q       <= 32'h0;
            pc_plus4_q <= 32'h0;
        end else if (bubble_i) begin
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
        end else if (load_i) begin
            valid_q    <= 1'b1;
            instr_q    <= instr_i;
            pc_q       <= pc_i;
            pc_plus4_q <= pc_plus4_i;
        end
    end

    assign valid_o    = valid_q;
    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4_q;
endmodule

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch: PC register, next-PC select, RUN/PEND redirect FSM,
// trap entry (exception / interrupt) with EPC capture, and the IF/ID register.
//   clk   : clock, all state updates on rising edge
//   reset : asynchronous active-low reset
//   bus   : fetch_stage_if.slave (controls, ROM port, IF/ID outputs, epc)
// Next-PC priority: exc > irq accept > (PEND release | redirect) > stall > +4.
// ----------------------------------------------------------------------------
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] IRQ_VECTOR = IRQ_VECTOR_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.slave  bus
);
    fstate_e     state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] pc_plus4, redir_tgt;
    logic        irq_acc, load, bubble;

    assign pc_plus4  = pc_q + 32'd4;            // wraps naturally mod 2^32
    assign redir_tgt = word_align(bus.redirect_pc);
    // PC bit 31 set means supervisor space; interrupts are masked there,
    // which also prevents re-entry while the handler runs.
    assign irq_acc   = bus.irq & ~pc_q[31];

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= RUN;
        else        state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        if (bus.exc || irq_acc) begin
            state_d = RUN;                      // trap discards a parked target
        end else if (state_q == PEND) begin
            if (!bus.stall) state_d = RUN;
        end else if (bus.redirect_valid && bus.stall) begin
            state_d = PEND;
        end
    end

    // FSM outputs / datapath controls
    always_comb begin
        pc_d   = pc_q;
        pend_d = pend_q;
        epc_d  = epc_q;
        load   = 1'b0;
        bubble = 1'b0;
        if (bus.exc) begin
            pc_d   = EXC_VECTOR;
            epc_d  = bus.id_pc;
            pend_d = 32'h0;
            bubble = 1'b1;
        end else if (irq_acc) begin
            pc_d   = IRQ_VECTOR;
            epc_d  = pc_q;
            pend_d = 32'h0;
            bubble = 1'b1;
        end else if (state_q == PEND) begin
            // Redirects are ignored while parked; release on first unstalled edge.
            if (!bus.stall) begin
                pc_d   = pend_q;
                pend_d = 32'h0;
                bubble = 1'b1;
            end
        end else if (bus.redirect_valid) begin
            if (bus.stall) begin
                pend_d = redir_tgt;
            end else begin
                pc_d   = redir_tgt;
                bubble = 1'b1;
            end
        end else if (!bus.stall) begin
            pc_d   = pc_plus4;
            load   = ~bus.flush;
            bubble = bus.flush;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q   <= word_align(RESET_PC);
            pend_q <= 32'h0;
            epc_q  <= 32'h0;
        end else begin
            pc_q   <= word_align(pc_d);
            pend_q <= pend_d;
            epc_q  <= epc_d;
        end
    end

    if_id_reg u_if_id (
        .clk        (clk),
        .reset      (reset),
        .load_i     (load),
        .bubble_i   (bubble),
        .instr_i    (bus.imem_rdata),
        .pc_i       (pc_q),
        .pc_plus4_i (pc_plus4),
        .valid_o    (bus.id_valid),
        .instr_o    (bus.id_instr),
        .pc_o       (bus.id_pc),
        .pc_plus4_o (bus.id_pc_plus4)
    );

    assign bus.imem_addr = pc_q;
    assign bus.if_pc     = pc_q;
    assign bus.epc       = epc_q;
endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage. A combinational ROM model returns
// 32'h2008_0005 at address 0 and (32'hC000_0000 | addr) elsewhere.
// ----------------------------------------------------------------------------
module tb_fetch_stage;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a == 32'h0) ? 32'h2008_0005 : (32'hC000_0000 | a);
    endfunction

    assign bus.imem_rdata = rom(bus.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, observed timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic fl, input logic rv,
                         input logic [31:0] rpc, input logic iq, input logic ex);
        bus.stall          = st;
        bus.flush          = fl;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.irq            = iq;
        bus.exc            = ex;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        drive(0, 0, 0, 32'h0, 0, 0);

        // Reset state
        #12;
        chk("rst if_pc",     bus.if_pc,       32'h0);
        chk("rst imem_addr", bus.imem_addr,   32'h0);
        chk("rst id_valid",  {31'h0, bus.id_valid}, 32'h0);
        chk("rst id_instr",  bus.id_instr,    32'h0);
        chk("rst id_pc",     bus.id_pc,       32'h0);
        chk("rst id_pc4",    bus.id_pc_plus4, 32'h0);
        chk("rst epc",       bus.epc,         32'h0);

        // First fetch on the first edge after release
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("first id_instr", bus.id_instr,    32'h2008_0005);
        chk("first id_pc",    bus.id_pc,       32'h0);
        chk("first id_pc4",   bus.id_pc_plus4, 32'h4);
        chk("first id_valid", {31'h0, bus.id_valid}, 32'h1);
        chk("first if_pc",    bus.if_pc,       32'h4);
        step();
        chk("seq if_pc",    bus.if_pc,    32'h8);
        chk("seq id_instr", bus.id_instr, 32'hC000_0004);

        // Redirect at if_pc=8
        drive(0, 0, 1, 32'h40, 0, 0);
        step();
        chk("redir if_pc",    bus.if_pc,    32'h40);
        chk("redir id_valid", {31'h0, bus.id_valid}, 32'h0);
        chk("redir id_instr", bus.id_instr, 32'h0);
        drive(0, 0, 0, 32'h0, 0, 0);
        step();
        chk("redir+1 id_pc",    bus.id_pc,    32'h40);
        chk("redir+1 id_instr", bus.id_instr, 32'hC000_0040);
        chk("redir+1 if_pc",    bus.if_pc,    32'h44);

        // Redirect under stall for 3 cycles, then release
        drive(1, 0, 1, 32'h80, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall if_pc",    bus.if_pc,    32'h44);
            chk("stall id_pc",    bus.id_pc,    32'h40);
            chk("stall id_instr", bus.id_instr, 32'hC000_0040);
            chk("stall id_valid", {31'h0, bus.id_valid}, 32'h1);
        end
        drive(0, 0, 0, 32'h0, 0, 0);
        step();
        chk("pend rel if_pc",    bus.if_pc, 32'h80);
        chk("pend rel id_valid", {31'h0, bus.id_valid}, 32'h0);
        step();
        chk("pend rel+1 if_pc", bus.if_pc, 32'h84);
        chk("pend rel+1 id_pc", bus.id_pc, 32'h80);

        // PEND ignores later redirects; low target bits are forced to zero
        drive(1, 0, 1, 32'h103, 0, 0);
        step();
        drive(1, 0, 1, 32'h200, 0, 0);
        step();
        chk("pend hold if_pc", bus.if_pc, 32'h84);
        drive(0, 0, 0, 32'h0, 0, 0);
        step();
        chk("pend ign if_pc", bus.if_pc, 32'h100);
        step();
        chk("pend ign+1 id_pc", bus.id_pc, 32'h100);
        chk("pend ign+1 if_pc", bus.if_pc, 32'h104);

        // Flush without stall: PC advances, bubble in IF/ID
        drive(0, 1, 0, 32'h0, 0, 0);
        step();
        chk("flush if_pc",    bus.if_pc, 32'h108);
        chk("flush id_valid", {31'h0, bus.id_valid}, 32'h0);
        chk("flush id_instr", bus.id_instr, 32'h0);
        drive(0, 0, 0, 32'h0, 0, 0);
        step();
        chk("flush+1 id_pc", bus.id_pc, 32'h108);
        chk("flush+1 if_pc", bus.if_pc, 32'h10C);
        // Flush with stall: everything holds
        drive(1, 1, 0, 32'h0, 0, 0);
        step();
        chk("flush stall if_pc",    bus.if_pc, 32'h10C);
        chk("flush stall id_valid", {31'h0, bus.id_valid}, 32'h1);
        chk("flush stall id_pc",    bus.id_pc, 32'h108);

        // Interrupt at if_pc=0x10, no re-entry in supervisor space
        drive(0, 0, 1, 32'h10, 0, 0);
        step();
        chk("pre irq if_pc", bus.if_pc, 32'h10);
        drive(0, 0, 0, 32'h0, 1, 0);
        step();
        chk("irq if_pc",    bus.if_pc, 32'h8000_0004);
        chk("irq epc",      bus.epc,   32'h10);
        chk("irq id_valid", {31'h0, bus.id_valid}, 32'h0);
        step();
        chk("irq2 if_pc", bus.if_pc, 32'h8000_0008);
        chk("irq2 epc",   bus.epc,   32'h10);
        step();
        chk("irq3 if_pc", bus.if_pc, 32'h8000_000C);
        chk("irq3 id_pc", bus.id_pc, 32'h8000_0008);
        chk("irq3 epc",   bus.epc,   32'h10);

        // Exception with stall and redirect, id_pc=0x20
        drive(0, 0, 1, 32'h1C, 0, 0);
        step();
        drive(0, 0, 0, 32'h0, 0, 0);
        step();
        step();
        chk("pre exc id_pc", bus.id_pc, 32'h20);
        drive(1, 0, 1, 32'h300, 0, 1);
        step();
        chk("exc if_pc",    bus.if_pc, 32'h8000_0008);
        chk("exc epc",      bus.epc,   32'h20);
        chk("exc id_valid", {31'h0, bus.id_valid}, 32'h0);
        drive(0, 0, 0, 32'h0, 0, 0);
        step();
        chk("exc run if_pc", bus.if_pc, 32'h8000_000C);

        // Exception while parked discards the pending target
        drive(1, 0, 1, 32'h400, 0, 0);
        step();
        drive(1, 0, 0, 32'h0, 0, 1);
        step();
        chk("exc pend if_pc", bus.if_pc, 32'h8000_0008);
        chk("exc pend epc",   bus.epc,   32'h8000_0008);
        drive(0, 0, 0, 32'h0, 0, 0);
        step();
        chk("exc pend drop if_pc", bus.if_pc, 32'h8000_000C);

        // Reset pulse while parked
        drive(1, 0, 1, 32'h500, 0, 0);
        step();
        chk("pend2 if_pc", bus.if_pc, 32'h8000_000C);
        #2;
        reset = 1'b0;
        #1;
        chk("async rst if_pc",    bus.if_pc, 32'h0);
        chk("async rst id_valid", {31'h0, bus.id_valid}, 32'h0);
        chk("async rst epc",      bus.epc,   32'h0);
        drive(0, 0, 0, 32'h0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("post rst if_pc",    bus.if_pc,    32'h4);
        chk("post rst id_instr", bus.id_instr, 32'h2008_0005);
        step();
        chk("post rst+1 if_pc", bus.if_pc, 32'h8);

        // PC wrap at the top of the address space
        drive(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        step();
        chk("wrap pre if_pc", bus.if_pc, 32'hFFFF_FFFC);
        drive(0, 0, 0, 32'h0, 0, 0);
        step();
        chk("wrap if_pc",    bus.if_pc,       32'h0);
        chk("wrap id_pc",    bus.id_pc,       32'hFFFF_FFFC);
        chk("wrap id_pc4",   bus.id_pc_plus4, 32'h0);
        chk("wrap id_instr", bus.id_instr,    32'hFFFF_FFFC);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC loaded on reset.
REQ-002 SHALL have parameter IRQ_VECTOR, default 32'h8000_0004, the interrupt entry PC.
REQ-003 SHALL have parameter EXC_VECTOR, default 32'h8000_0008, the exception entry PC.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port stall  in  1  hold the PC and the IF/ID register.
REQ-007 SHALL have port flush  in  1  squash the instruction entering IF/ID.
REQ-008 SHALL have port redirect_valid  in  1  branch/jump taken.
REQ-009 SHALL have port redirect_pc  in  32  branch/jump target.
REQ-010 SHALL have port irq  in  1  level interrupt request.
REQ-011 SHALL have port exc  in  1  one-cycle exception pulse from decode.
REQ-012 SHALL have port imem_addr  out  32  instruction ROM address; combinationally equals if_pc.
REQ-013 SHALL have port imem_rdata  in  32  ROM data, combinational, same cycle.
REQ-014 SHALL have port if_pc  out  32  current fetch PC register.
REQ-015 SHALL have port id_valid, id_instr, id_pc, id_pc_plus4  out  1/32/32/32  IF/ID register.
REQ-016 SHALL have port epc  out  32  return PC captured on interrupt or exception acceptance.

Function
REQ-017 SHALL apply per-edge priority: exc > irq-accept > redirect > stall > sequential.
REQ-018 SHALL accept an interrupt only when irq=1 and if_pc[31]=0 (user mode).
REQ-019 On exc: if_pc<=EXC_VECTOR, epc<=id_pc, id_valid<=0, regardless of stall.
REQ-020 On irq-accept: if_pc<=IRQ_VECTOR, epc<=if_pc, id_valid<=0, regardless of stall.
REQ-021 On redirect without stall: if_pc<=redirect_pc, IF/ID<=bubble (id_valid=0, id_instr=0).
REQ-022 On stall without redirect: if_pc and the entire IF/ID register SHALL hold.
REQ-023 On sequential fetch: if_pc<=if_pc+4 (mod 2^32, wraps at 32'hFFFF_FFFC), id_instr<=imem_rdata, id_pc<=if_pc, id_pc_plus4<=if_pc+4, id_valid<=1.
REQ-024 On flush without stall: PC advances per REQ-017, IF/ID<=bubble.
REQ-025 SHALL use a 2-state FSM, RUN and PEND.
REQ-026 Transition RUN->PEND when redirect_valid=1 and stall=1: latch redirect_pc into pend_pc, hold PC and IF/ID.
REQ-027 In PEND, new redirects SHALL be ignored; at the first stall=0 edge, if_pc<=pend_pc, IF/ID<=bubble, state->RUN.
REQ-028 exc or irq-accept in PEND SHALL discard pend_pc and return to RUN.
REQ-029 if_pc[1:0] SHALL always be 2'b00; redirect_pc[1:0] SHALL be forced to 0.
REQ-030 epc SHALL change only on exc or irq-accept.

Reset
REQ-031 On reset=0, asynchronously: if_pc=RESET_PC, state=RUN, pend_pc=0, id_valid=0, id_instr=0, id_pc=0, id_pc_plus4=0, epc=0.
REQ-032 Reset mid-PEND SHALL drop the pending target.
REQ-033 The first fetch SHALL occur at the first rising edge after reset deasserts.

Structure
REQ-034 The shared CPU package SHALL hold the vector constants, the NOP encoding (32'h0) and the FSM state type.
REQ-035 The IF/ID register SHALL be a sub-module, if_id_reg, with load/bubble/hold controls.
REQ-036 The PC-select mux and FSM SHALL live in fetch_stage.

Verification
REQ-037 Reset release with ROM[0]=32'h2008_0005: after 1 edge id_instr=32'h2008_0005, id_pc=0, if_pc=4.
REQ-038 redirect_valid=1, redirect_pc=32'h0000_0040 at if_pc=8: next if_pc=32'h40, id_valid=0; following edge id_pc=32'h40.
REQ-039 stall=1 with redirect to 32'h80 for 3 cycles: if_pc and IF/ID constant; stall=0 -> if_pc=32'h80, id_valid=0.
REQ-040 irq=1 at if_pc=32'h0000_0010: next if_pc=32'h8000_0004, epc=32'h10; with irq still 1 at if_pc=32'h8000_0008, no re-entry.
REQ-041 exc with stall=1 and redirect in the same cycle, id_pc=32'h0000_0020: if_pc=32'h8000_0008, epc=32'h20, state=RUN.
REQ-042 reset pulse while in PEND: if_pc=RESET_PC immediately, id_valid=0, pending target never taken.
